sumador_mac_ctrl: RTL

- Sequencer that time-shares one combinational `Sumador` (2N-bit adder, ports `Sum_ext`/`Multiplica`/`Suma_G`) to accumulate a stream of multiplier products into a multiply-accumulate result.
- Accepts a job of `num_terms` products over a valid/ready stream. Drives the adder with (accumulator, product), registers the sum back, and presents the final sum on an output valid/ready handshake.
- Sits between the multiplier output and the downstream result consumer.

---
 rtl/sumador_mac_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/sumador_mac_ctrl.sv
// sumador_mac_ctrl: sequencer that time-shares one external combinational 2N-bit adder
// (Sumador) to accumulate a job of num_terms signed products into one MAC result.
//
// Ports:
//   CLK, RST_N             clock (rising edge) and synchronous active-low reset
//   start, num_terms       job start pulse and product count (sampled in IDLE only)
//   busy                   high whenever the controller is not idle
//   prod_data/valid/ready  product stream from the multiplier
//   Multiplica, Sum_ext    operands driven to the shared adder
//   Suma_G                 adder result, combinational from Multiplica and Sum_ext
//   acc_out/out_valid/ready  final result handshake to the consumer
//   ovf                    sticky signed-overflow flag for the current or last job
module sumador_mac_ctrl #(
  parameter int unsigned N     = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] num_terms,
  output logic             busy,
  input  logic [2*N-1:0]   prod_data,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [2*N-1:0]   Multiplica,
  output logic [2*N-1:0]   Sum_ext,
  input  logic [2*N-1:0]   Suma_G,
  output logic [2*N-1:0]   acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int unsigned W = 2 * N;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    Multiplica = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = num_terms;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          // An empty job completes immediately with a zero result.
          state_d = (num_terms == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        prod_ready = 1'b1;
        Multiplica = prod_data;
        if (prod_valid) begin
          acc_d   = Suma_G;
          count_d = count_q + LEN_W'(1);
          // Two's-complement wrap: like-signed operands yielding an opposite-signed sum.
          if ((acc_q[W-1] == prod_data[W-1]) && (Suma_G[W-1] != acc_q[W-1])) begin
            ovf_d = 1'b1;
          end
          // len_q >= 1 here, so len_q - 1 cannot underflow.
          if (count_q == len_q - LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign Sum_ext = acc_q;
  // acc is cleared by reset and retained after hand-off, so it can drive the port directly.
  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule
